// File: rtl/pll_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_pkg
//  Description : Shared definitions for the PLL reset sequencer: the
//                sequencer state encoding and the helper that sizes the
//                shared cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_t;

    // Width of a counter that must reach (max_cycles - 1) for the largest of
    // the four cycle parameters. Never narrower than one bit.
    function automatic int cnt_width(input int a, input int b,
                                     input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop single-bit synchronizer with asynchronous,
//                active-high reset to 0.
//  Ports       : clk  - destination clock
//                rst  - asynchronous active-high reset
//                i_d  - asynchronous input bit
//                o_q  - synchronized output
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reset_seq
//  Description : PLL reset sequencer on the free-running reference clock.
//                Pulses the PLL reset, waits for lock, requires lock to be
//                stable for STABLE_CYCLES plus HOLD_CYCLES before releasing
//                the system reset, and re-asserts it on any lock loss.
//  Config      : define PLL_RESET_SEQ_TIMEOUT_EN to re-pulse the PLL reset
//                after TIMEOUT_CYCLES without lock (retries indefinitely).
//  Ports       : clk          - 50 MHz free-running reference clock
//                rst          - asynchronous active-high reset
//                locked       - raw PLL lock (asynchronous)
//                soft_rst_req - one-cycle request to restart the sequence
//                pll_rst      - reset to the PLL
//                sys_rst      - active-high system reset
//                ready        - high only while running
//                loss_count   - saturating count of lock losses in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 16,
    parameter int PLL_RST_CYCLES = 8,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             soft_rst_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count
);

    localparam int c_cw = cnt_width(STABLE_CYCLES, HOLD_CYCLES,
                                    PLL_RST_CYCLES, TIMEOUT_CYCLES);

    localparam logic [c_cw-1:0] c_pll_rst_last = c_cw'(PLL_RST_CYCLES - 1);
    localparam logic [c_cw-1:0] c_stable_last  = c_cw'(STABLE_CYCLES - 1);
    localparam logic [c_cw-1:0] c_hold_last    = c_cw'(HOLD_CYCLES - 1);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    localparam logic [c_cw-1:0] c_timeout_last = c_cw'(TIMEOUT_CYCLES - 1);
`endif

    logic             w_locked_sync;
    logic             r_locked_s;
    state_t           r_state;
    state_t           w_state_next;
    logic [c_cw-1:0]  r_cnt;
    logic [c_cw-1:0]  w_cnt_next;
    logic             w_loss_event;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic [CNT_W-1:0] r_loss_count;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (locked),
        .o_q (w_locked_sync)
    );

    // The sequence consumes the synchronizer output through one more flop,
    // so a lock change reaches the state register three edges after the
    // edge that first samples it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_locked_s <= 1'b0;
        else     r_locked_s <= w_locked_sync;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_loss_event = 1'b0;
        case (r_state)
            PLL_RST: begin
                if (r_cnt == c_pll_rst_last) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end
            end
            WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_next = STABLE;
                    w_cnt_next   = '0;
                end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
                else if (r_cnt == c_timeout_last) begin
                    w_state_next = PLL_RST;
                    w_cnt_next   = '0;
                end
`else
                else begin
                    w_cnt_next = '0;
                end
`endif
            end
            STABLE: begin
                if (!r_locked_s) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end
            end
            HOLD: begin
                if (!r_locked_s) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_hold_last) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end
            end
            RUN: begin
                w_cnt_next = '0;
                if (!r_locked_s) begin
                    w_state_next = WAIT_LOCK;
                    w_loss_event = 1'b1;
                end
            end
            default: begin
                w_state_next = PLL_RST;
                w_cnt_next   = '0;
            end
        endcase
        // A soft restart overrides every transition, but a coincident lock
        // loss in RUN is still counted.
        if (soft_rst_req) begin
            w_state_next = PLL_RST;
            w_cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= PLL_RST;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_sys_rst    <= 1'b1;
            r_ready      <= 1'b0;
            r_loss_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            // Outputs decode the next state so they move with the state.
            r_pll_rst <= (w_state_next == PLL_RST);
            r_sys_rst <= (w_state_next != RUN);
            r_ready   <= (w_state_next == RUN);
            if (w_loss_event && (r_loss_count != {CNT_W{1'b1}}))
                r_loss_count <= r_loss_count + 1'b1;
        end
    end

    assign pll_rst    = r_pll_rst;
    assign sys_rst    = r_sys_rst;
    assign ready      = r_ready;
    assign loss_count = r_loss_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reset_seq
//  Description : Directed self-checking bench for pll_reset_seq with
//                STABLE=8, HOLD=4, PLL_RST=3, TIMEOUT=32, CNT_W=2.
//                Expectations follow the PLL_RESET_SEQ_TIMEOUT_EN setting.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_seq;

    localparam int c_stable  = 8;
    localparam int c_hold    = 4;
    localparam int c_pllrst  = 3;
    localparam int c_timeout = 32;
    localparam int c_cnt_w   = 2;
    localparam int c_release = 3 + c_stable + c_hold;   // 15 edges
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    localparam logic c_to_en = 1'b1;
`else
    localparam logic c_to_en = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               locked;
    logic               soft_rst_req;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic [c_cnt_w-1:0] loss_count;

    int n_vectors     = 0;
    int n_miscompares = 0;

    pll_reset_seq #(
        .STABLE_CYCLES  (c_stable),
        .HOLD_CYCLES    (c_hold),
        .PLL_RST_CYCLES (c_pllrst),
        .TIMEOUT_CYCLES (c_timeout),
        .CNT_W          (c_cnt_w)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .loss_count   (loss_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // locked has just been raised; the next edge is edge 0.
    task automatic expect_release(input string tag);
        for (int k = 0; k <= c_release; k++) begin
            tick();
            if (k == c_release - 1) check({tag, "_sys_rst_early"}, 32'(sys_rst), 32'd1);
            if (k == c_release) begin
                check({tag, "_sys_rst_rel"}, 32'(sys_rst), 32'd0);
                check({tag, "_ready"}, 32'(ready), 32'd1);
            end
        end
    endtask

    // In RUN: drop locked; sys_rst must rise at edge 3.
    task automatic lose_lock(input string tag, input int exp_count);
        locked = 1'b0;
        repeat (3) tick();
        check({tag, "_ready_e2"}, 32'(ready), 32'd1);
        tick();
        check({tag, "_sys_rst_e3"}, 32'(sys_rst), 32'd1);
        check({tag, "_ready_e3"}, 32'(ready), 32'd0);
        check({tag, "_loss"}, 32'(loss_count), 32'(exp_count));
    endtask

    // Check a PLL reset pulse that started on the previous edge (or on
    // reset release): high for the next edges, falling on the last.
    task automatic pll_pulse(input string tag);
        for (int k = 1; k <= c_pllrst; k++) begin
            tick();
            check({tag, "_pll_rst"}, 32'(pll_rst), (k < c_pllrst) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        locked       = 1'b0;
        soft_rst_req = 1'b0;
        repeat (3) tick();
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_sys_rst", 32'(sys_rst), 32'd1);
        check("rst_ready",   32'(ready),   32'd0);
        check("rst_loss",    32'(loss_count), 32'd0);

        // Bring-up: pll_rst high for three edges after release.
        rst = 1'b0;
        pll_pulse("bringup");
        repeat (5) tick();
        check("wait_sys_rst", 32'(sys_rst), 32'd1);
        locked = 1'b1;
        expect_release("bringup");

        lose_lock("loss1", 1);

        // Relock, then a one-cycle glitch seen by the FSM at STABLE count 5.
        locked = 1'b1;
        repeat (6) tick();            // edges 0..5
        locked = 1'b0;
        tick();                       // edge 6 samples the low
        locked = 1'b1;                // next edge is the re-rise edge
        expect_release("glitch");

        // Soft restart on the same edge the FSM sees the lock loss.
        locked = 1'b0;
        repeat (3) tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check("soft_pll_rst", 32'(pll_rst), 32'd1);
        check("soft_sys_rst", 32'(sys_rst), 32'd1);
        check("soft_ready",   32'(ready),   32'd0);
        check("soft_loss",    32'(loss_count), 32'd2);
        pll_pulse("soft");
        repeat (5) tick();
        locked = 1'b1;
        expect_release("soft");

        lose_lock("loss3", 3);
        locked = 1'b1;
        expect_release("loss3");
        lose_lock("loss4", 3);        // saturated

        // Lock held low: WAIT_LOCK entered at edge E (the loss edge above).
        repeat (31) tick();
        check("to_e31", 32'(pll_rst), 32'd0);
        tick();
        check("to_e32", 32'(pll_rst), 32'(c_to_en));
        repeat (2) tick();
        check("to_e34", 32'(pll_rst), 32'(c_to_en));
        tick();
        check("to_e35", 32'(pll_rst), 32'd0);
        repeat (31) tick();
        check("to_e66", 32'(pll_rst), 32'd0);
        tick();
        check("to_e67", 32'(pll_rst), 32'(c_to_en));

        // Relock into HOLD (STABLE at edge 3, HOLD from edge 11 to 15),
        // then assert rst asynchronously between edges.
        locked = 1'b1;
        repeat (13) tick();
        check("hold_sys_rst", 32'(sys_rst), 32'd1);
        check("hold_ready",   32'(ready),   32'd0);
        #3 rst = 1'b1;
        #1;
        check("arst_pll_rst", 32'(pll_rst), 32'd1);
        check("arst_sys_rst", 32'(sys_rst), 32'd1);
        check("arst_ready",   32'(ready),   32'd0);
        check("arst_loss",    32'(loss_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
